// File: rtl/audio_hit_detector.sv
// Peak-envelope clap/whack detector reading mic samples from the Audio_Controller input FIFO.
// Latency: a sample popped in cycle N updates env at the next edge; a hit can be seen in cycle N+2.
// Backpressure: a sample is popped only when one is available and the output side has room; otherwise env and holdoff hold.
//
// Ports:
//   clock, resetn                  system clock, asynchronous active-low reset
//   enable                         detector runs while high; low forces IDLE
//   audio_in_available             input FIFO has a sample
//   audio_out_allowed              output FIFO has room (keeps lockstep with loopback writer)
//   left/right_channel_audio_in    signed 32-bit samples
//   read_audio_in                  pop strobe (combinational)
//   hit                            one-cycle pulse per detected hit
//   armed                          high while waiting for a hit
//   level                          env[30:23] for the LED meter
//   hit_count                      hits since reset / enable rise, saturating at 255
module audio_hit_detector #(
    parameter logic [31:0] HIGH_THRESH     = 32'd20000000,
    parameter logic [31:0] LOW_THRESH      = 32'd8000000,
    parameter int unsigned ATTACK_SHIFT    = 2,
    parameter int unsigned DECAY_SHIFT     = 6,
    parameter int unsigned HOLDOFF_SAMPLES = 4800
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        enable,
    input  logic        audio_in_available,
    input  logic        audio_out_allowed,
    input  logic [31:0] left_channel_audio_in,
    input  logic [31:0] right_channel_audio_in,
    output logic        read_audio_in,
    output logic        hit,
    output logic        armed,
    output logic [7:0]  level,
    output logic [7:0]  hit_count
);

    localparam logic [15:0] HOLD_LIM = 16'(HOLDOFF_SAMPLES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_HIT,
        S_HOLDOFF
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] env_q, env_d;
    logic [15:0] hold_q, hold_d;
    logic [7:0]  cnt_q, cnt_d;

    logic        strobe;
    logic [31:0] mag_l, mag_r, mag;

    // Magnitude of a signed sample; the most negative value has no positive
    // twin, so it saturates instead of wrapping back to itself.
    function automatic logic [31:0] sat_abs(input logic [31:0] x);
        logic [31:0] r;
        if (!x[31]) begin
            r = x;
        end else if (x == 32'h8000_0000) begin
            r = 32'h7FFF_FFFF;
        end else begin
            r = (~x) + 32'd1;
        end
        return r;
    endfunction

    assign read_audio_in = audio_in_available & audio_out_allowed;
    assign strobe        = read_audio_in;

    assign mag_l = sat_abs(left_channel_audio_in);
    assign mag_r = sat_abs(right_channel_audio_in);
    assign mag   = (mag_l > mag_r) ? mag_l : mag_r;

    // Fast attack / slow decay peak follower. mag < 2^31 so the sum never wraps.
    always_comb begin
        env_d = env_q;
        if (strobe) begin
            if (mag > env_q) begin
                env_d = env_q + ((mag - env_q) >> ATTACK_SHIFT);
            end else begin
                env_d = env_q - (env_q >> DECAY_SHIFT);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    state_d = S_ARMED;
                    cnt_d   = 8'd0;
                end
            end
            S_ARMED: begin
                if (env_q >= HIGH_THRESH) begin
                    state_d = S_HIT;
                end
            end
            S_HIT: begin
                // Counted even if enable drops now: the pulse is already out.
                state_d = S_HOLDOFF;
                hold_d  = 16'd0;
                if (cnt_q != 8'hFF) begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_HOLDOFF: begin
                // Re-arm needs both the minimum sample gap and the envelope
                // falling under the lower threshold (hysteresis).
                if ((hold_q == HOLD_LIM) && (env_q < LOW_THRESH)) begin
                    state_d = S_ARMED;
                end else if (strobe && (hold_q != HOLD_LIM)) begin
                    hold_d = hold_q + 16'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (!enable) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            env_q   <= 32'd0;
            hold_q  <= 16'd0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            env_q   <= env_d;
            hold_q  <= hold_d;
            cnt_q   <= cnt_d;
        end
    end

    assign hit       = (state_q == S_HIT);
    assign armed     = (state_q == S_ARMED);
    assign level     = env_q[30:23];
    assign hit_count = cnt_q;

endmodule

// File: tb/tb_audio_hit_detector.sv
module tb_audio_hit_detector;

    localparam longint HIGH = 20000000;
    localparam longint LOW  = 8000000;
    localparam int     ATT  = 2;
    localparam int     DEC  = 6;
    localparam int     HOLD = 4800;

    logic        clock;
    logic        resetn;
    logic        enable;
    logic        audio_in_available;
    logic        audio_out_allowed;
    logic [31:0] left_channel_audio_in;
    logic [31:0] right_channel_audio_in;
    logic        read_audio_in;
    logic        hit;
    logic        armed;
    logic [7:0]  level;
    logic [7:0]  hit_count;

    audio_hit_detector dut (
        .clock                  (clock),
        .resetn                 (resetn),
        .enable                 (enable),
        .audio_in_available     (audio_in_available),
        .audio_out_allowed      (audio_out_allowed),
        .left_channel_audio_in  (left_channel_audio_in),
        .right_channel_audio_in (right_channel_audio_in),
        .read_audio_in          (read_audio_in),
        .hit                    (hit),
        .armed                  (armed),
        .level                  (level),
        .hit_count              (hit_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_err    = 0;
    int n_checks = 0;
    int dut_hits = 0;

    // Reference model: envelope as a plain integer, behaviour as flags and a
    // countdown of samples still required before re-arming is allowed.
    longint m_env;
    bit     m_active;   // enabled and out of idle
    bit     m_waiting;  // ready to fire
    bit     m_pulse;    // hit pulse visible this cycle
    bit     m_quiet;    // post-hit quiet period
    int     m_left;     // samples left in the quiet period
    int     m_count;

    function automatic longint mag_of(input logic [31:0] x);
        longint v;
        v = longint'($signed(x));
        if (v < 0) v = -v;
        if (v > 64'd2147483647) v = 64'd2147483647;
        return v;
    endfunction

    function automatic void model_reset();
        m_env = 0; m_active = 0; m_waiting = 0; m_pulse = 0;
        m_quiet = 0; m_left = 0; m_count = 0;
    endfunction

    function automatic void model_step(input bit en, input bit stb,
                                       input logic [31:0] l, input logic [31:0] r);
        longint a, b, mag, nenv;
        a = mag_of(l);
        b = mag_of(r);
        mag = (a > b) ? a : b;
        nenv = m_env;
        if (stb) begin
            if (mag > m_env) nenv = m_env + (mag - m_env) / (64'd1 << ATT);
            else             nenv = m_env - m_env / (64'd1 << DEC);
        end
        if (m_pulse && m_count < 255) m_count++;
        if (!en) begin
            m_active = 0; m_waiting = 0; m_pulse = 0; m_quiet = 0;
        end else if (!m_active) begin
            m_active = 1; m_waiting = 1; m_count = 0;
        end else if (m_pulse) begin
            m_pulse = 0; m_quiet = 1; m_left = HOLD;
        end else if (m_waiting) begin
            if (m_env >= HIGH) begin m_waiting = 0; m_pulse = 1; end
        end else if (m_quiet) begin
            if (m_left == 0 && m_env < LOW) begin m_quiet = 0; m_waiting = 1; end
            else if (stb && m_left > 0) m_left--;
        end
        m_env = nenv;
    endfunction

    function automatic logic [7:0] m_level();
        return 8'((m_env / 64'd8388608) % 256);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, check the pop strobe, clock, advance model, check outputs.
    task automatic cyc(input bit en, input bit av, input bit al,
                       input logic [31:0] l, input logic [31:0] r);
        enable = en; audio_in_available = av; audio_out_allowed = al;
        left_channel_audio_in = l; right_channel_audio_in = r;
        #1;
        chk("read", {31'd0, read_audio_in}, {31'd0, av & al});
        @(posedge clock);
        if (!resetn) model_reset();
        else         model_step(en, av & al, l, r);
        #1;
        if (hit === 1'b1) dut_hits++;
        chk("hit",   {31'd0, hit},       {31'd0, m_pulse});
        chk("armed", {31'd0, armed},     {31'd0, m_waiting});
        chk("level", {24'd0, level},     {24'd0, m_level()});
        chk("count", {24'd0, hit_count}, m_count[31:0]);
    endtask

    initial begin
        int n;
        logic [7:0] lv;
        logic [31:0] x, y;
        model_reset();
        resetn = 1'b0; enable = 1'b0; audio_in_available = 1'b0; audio_out_allowed = 1'b0;
        left_channel_audio_in = 32'd0; right_channel_audio_in = 32'd0;

        // 1: reset holds everything quiet while the strobe still follows inputs
        repeat (3) cyc(1, 1, 1, 32'h7FFF_FFFF, 32'h8000_0000);
        chk("rst_hit", {31'd0, hit}, 32'd0);
        chk("rst_level", {24'd0, level}, 32'd0);
        cyc(1, 1, 0, 32'h7FFF_FFFF, 32'd0);
        chk("rst_armed", {31'd0, armed}, 32'd0);
        resetn = 1'b1;

        // 2: single hit with exact latency
        cyc(1, 0, 1, 32'd0, 32'd0);
        chk("t2_armed", {31'd0, armed}, 32'd1);
        cyc(1, 1, 1, 32'h4000_0000, 32'd0);     // strobe cycle N
        chk("t2_level", {24'd0, level}, 32'h20); // env = 0x10000000
        chk("t2_nohit_n1", {31'd0, hit}, 32'd0);
        cyc(1, 0, 1, 32'd0, 32'd0);
        chk("t2_hit_n2", {31'd0, hit}, 32'd1);
        cyc(1, 0, 1, 32'd0, 32'd0);
        chk("t2_pulse_end", {31'd0, hit}, 32'd0);
        chk("t2_count", {24'd0, hit_count}, 32'd1);

        // 3: sustained loud input yields one hit only
        for (int i = 0; i < 10000; i++) cyc(1, 1, 1, 32'h4000_0000, 32'hC000_0000);
        chk("t3_hits", dut_hits, 32'd1);
        chk("t3_count", {24'd0, hit_count}, 32'd1);

        // 4: decay to re-arm, then a second burst
        n = 0;
        while (armed !== 1'b1 && n < 2000) begin cyc(1, 1, 1, 32'd0, 32'd0); n++; end
        chk("t4_rearm1", {31'd0, armed}, 32'd1);
        cyc(1, 1, 1, 32'h4000_0000, 32'd0);
        cyc(1, 0, 1, 32'd0, 32'd0);
        chk("t4_hit2", {31'd0, hit}, 32'd1);
        cyc(1, 0, 1, 32'd0, 32'd0);
        chk("t4_count2", {24'd0, hit_count}, 32'd2);
        n = 0;
        while (armed !== 1'b1 && n < 6000) begin cyc(1, 1, 1, 32'd0, 32'd0); n++; end
        chk("t4_rearm2", {31'd0, armed}, 32'd1);
        chk("t4_holdoff_len", {31'd0, n >= HOLD}, 32'd1);
        cyc(1, 1, 1, 32'h4000_0000, 32'd0);
        cyc(1, 0, 1, 32'd0, 32'd0);
        cyc(1, 0, 1, 32'd0, 32'd0);
        chk("t4_count3", {24'd0, hit_count}, 32'd3);

        // 5: no consumption without room on the output side
        lv = level;
        cyc(1, 1, 0, 32'h7FFF_FFFF, 32'd0);
        chk("t5_env_hold", {24'd0, level}, {24'd0, lv});
        cyc(1, 1, 1, 32'h7FFF_FFFF, 32'd0);
        chk("t5_consumed", {31'd0, level != lv}, 32'd1);

        // 6: enable drop in holdoff, re-enable clears count, most-negative sample
        cyc(0, 0, 1, 32'd0, 32'd0);
        chk("t6_idle", {31'd0, armed}, 32'd0);
        repeat (600) cyc(0, 1, 1, 32'd0, 32'd0);
        cyc(1, 0, 1, 32'd0, 32'd0);
        chk("t6_armed", {31'd0, armed}, 32'd1);
        chk("t6_count0", {24'd0, hit_count}, 32'd0);
        cyc(1, 1, 1, 32'h8000_0000, 32'd0);
        chk("t6_sat_level", {24'd0, level}, {24'd0, m_level()});
        cyc(1, 0, 1, 32'd0, 32'd0);
        chk("t6_sat_hit", {31'd0, hit}, 32'd1);
        cyc(1, 0, 1, 32'd0, 32'd0);
        chk("t6_count1", {24'd0, hit_count}, 32'd1);

        // Mid-operation asynchronous reset
        @(negedge clock);
        resetn = 1'b0;
        model_reset();
        #1;
        chk("mr_hit", {31'd0, hit}, 32'd0);
        chk("mr_level", {24'd0, level}, 32'd0);
        chk("mr_count", {24'd0, hit_count}, 32'd0);
        cyc(1, 1, 1, 32'h7FFF_FFFF, 32'd0);
        resetn = 1'b1;
        n = dut_hits;
        repeat (5) cyc(1, 1, 1, 32'd0, 32'd0);
        chk("mr_nohit", dut_hits - n, 32'd0);

        // Randomized bursts of loud and quiet input with random handshake
        for (int b = 0; b < 40; b++) begin
            bit loud;
            int len;
            loud = ($urandom_range(0, 2) == 0);
            len  = loud ? $urandom_range(5, 100) : $urandom_range(50, 400);
            for (int i = 0; i < len; i++) begin
                if (loud) begin
                    x = $urandom();
                    y = $urandom();
                end else begin
                    x = $urandom_range(0, 1 << 20);
                    y = $urandom_range(0, 1 << 20);
                    if ($urandom_range(0, 1) == 1) x = -x;
                    if ($urandom_range(0, 1) == 1) y = -y;
                end
                cyc($urandom_range(0, 299) != 0, $urandom_range(0, 3) != 0,
                    $urandom_range(0, 3) != 0, x, y);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
